// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl
// Bridges single core load/store requests onto a word-wide memory with a
// shared bidirectional data bus. Sub-word stores become a read-modify-write
// sequence. Lanes are big-endian within the word.
//
// Parameters
//   WORD_SIZE    data word width in bits (lane math assumes four byte lanes)
//   ADDRESS_SIZE memory word-address width
//   TIMEOUT      maximum cycles spent in one memory access before giving up
//
// Ports
//   clk, rst         clock (rising edge) / asynchronous active-low reset
//   req_*            core request: valid/ready handshake, write, size, signed,
//                    byte address, right-aligned store data
//   resp_*           one-cycle completion pulse with load data and error flag
//   mem_enable       memory ENABLE
//   mem_rnw          memory READNOTWRITE
//   mem_address      memory word address
//   mem_data         shared data bus (driven here only while writing)
//   mem_data_ready   memory DATA_READY (sticky, so ignored on an access's first cycle)
module lsu_mem_ctrl #(
  parameter int WORD_SIZE    = 32,
  parameter int ADDRESS_SIZE = 16,
  parameter int TIMEOUT      = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_signed,
  input  logic [31:0]             req_addr,
  input  logic [WORD_SIZE-1:0]    req_wdata,
  output logic                    resp_valid,
  output logic [WORD_SIZE-1:0]    resp_rdata,
  output logic                    resp_err,
  output logic                    mem_enable,
  output logic                    mem_rnw,
  output logic [ADDRESS_SIZE-1:0] mem_address,
  inout  wire  [WORD_SIZE-1:0]    mem_data,
  input  logic                    mem_data_ready
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, RD, WR, RMW_RD, GAP, RMW_WR, RESP
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [1:0]           size_q;
  logic                 signed_q;
  logic [1:0]           off_q;
  logic [WORD_SIZE-1:0] wdata_q;

  logic addr_err;
  logic access_done;
  logic access_timeout;
  logic unused_addr_bits;

  // Address bits above the memory's word address range are not decoded.
  assign unused_addr_bits = ^req_addr[31:ADDRESS_SIZE+2];

  // Pick the addressed lane out of a memory word and extend it to a full word.
  // Offset 0 is the most significant lane.
  function automatic logic [WORD_SIZE-1:0] load_extract(
    input logic [WORD_SIZE-1:0] word,
    input logic [1:0]           size,
    input logic [1:0]           off,
    input logic                 sgn
  );
    logic [7:0]           b;
    logic [15:0]          h;
    logic [WORD_SIZE-1:0] r;
    b = 8'(word >> (WORD_SIZE - 8 - 8 * int'(off)));
    h = 16'(word >> (WORD_SIZE - 16 - 8 * int'(off)));
    case (size)
      2'b00:   r = sgn ? {{(WORD_SIZE-8){b[7]}}, b}   : {{(WORD_SIZE-8){1'b0}}, b};
      2'b01:   r = sgn ? {{(WORD_SIZE-16){h[15]}}, h} : {{(WORD_SIZE-16){1'b0}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Overlay the low byte/half of the store data onto the addressed lane of
  // the word just read back from memory.
  function automatic logic [WORD_SIZE-1:0] store_merge(
    input logic [WORD_SIZE-1:0] word,
    input logic [WORD_SIZE-1:0] wdata,
    input logic [1:0]           size,
    input logic [1:0]           off
  );
    logic [WORD_SIZE-1:0] mask;
    logic [WORD_SIZE-1:0] data;
    logic [WORD_SIZE-1:0] r;
    case (size)
      2'b00: begin
        mask = {{(WORD_SIZE-8){1'b0}}, 8'hFF} << (WORD_SIZE - 8 - 8 * int'(off));
        data = {{(WORD_SIZE-8){1'b0}}, wdata[7:0]} << (WORD_SIZE - 8 - 8 * int'(off));
        r    = (word & ~mask) | data;
      end
      2'b01: begin
        mask = {{(WORD_SIZE-16){1'b0}}, 16'hFFFF} << (WORD_SIZE - 16 - 8 * int'(off));
        data = {{(WORD_SIZE-16){1'b0}}, wdata[15:0]} << (WORD_SIZE - 16 - 8 * int'(off));
        r    = (word & ~mask) | data;
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

  // Reserved size or a lane that straddles its natural alignment is refused
  // outright, before any memory traffic.
  assign addr_err = (req_size == 2'b11) ||
                    (req_size == 2'b01 && req_addr[0]) ||
                    (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  // The ready flag may still be high from the previous access, so it only
  // counts once at least one cycle of the current access has elapsed.
  assign access_done    = (cnt != '0) && mem_data_ready;
  assign access_timeout = (cnt == CNT_W'(TIMEOUT - 1));

  // The bus is driven only while a write cycle is being presented.
  assign mem_data = (mem_enable && !mem_rnw) ? wdata_q : {WORD_SIZE{1'bz}};

  // Main controller: one FSM with every output registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      off_q       <= 2'b00;
      wdata_q     <= '0;
      req_ready   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      mem_enable  <= 1'b0;
      mem_rnw     <= 1'b1;
      mem_address <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            size_q    <= req_size;
            signed_q  <= req_signed;
            off_q     <= req_addr[1:0];
            wdata_q   <= req_wdata;
            if (addr_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              cnt         <= '0;
              mem_enable  <= 1'b1;
              mem_address <= req_addr[ADDRESS_SIZE+1:2];
              if (!req_write) begin
                state   <= RD;
                mem_rnw <= 1'b1;
              end else if (req_size == 2'b10) begin
                state   <= WR;
                mem_rnw <= 1'b0;
              end else begin
                state   <= RMW_RD;
                mem_rnw <= 1'b1;
              end
            end
          end
        end

        RD, WR, RMW_RD, RMW_WR: begin
          if (access_done) begin
            mem_enable <= 1'b0;
            mem_rnw    <= 1'b1;
            if (state == RMW_RD) begin
              wdata_q <= store_merge(mem_data, wdata_q, size_q, off_q);
              state   <= GAP;
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= (state == RD) ?
                            load_extract(mem_data, size_q, off_q, signed_q) : '0;
            end
          end else if (access_timeout) begin
            state      <= RESP;
            mem_enable <= 1'b0;
            mem_rnw    <= 1'b1;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // One dead cycle between the read and write halves of a RMW.
        GAP: begin
          state      <= RMW_WR;
          cnt        <= '0;
          mem_enable <= 1'b1;
          mem_rnw    <= 1'b0;
        end

        RESP: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end

        default: begin
          state      <= IDLE;
          mem_enable <= 1'b0;
          mem_rnw    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/lsu_mem_ctrl.md
LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32: data word width in bits.
REQ-002 SHALL have parameter ADDRESS_SIZE, default 16: memory word-address width.
REQ-003 SHALL have parameter TIMEOUT, default 15: maximum wait cycles for mem_data_ready per memory access.
REQ-004 SHALL have port clk, in, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, in, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port req_valid, in, 1: core access request.
REQ-007 SHALL have port req_ready, out, 1: request accepted on an edge where req_valid && req_ready.
REQ-008 SHALL have port req_write, in, 1: 1 = store, 0 = load.
REQ-009 SHALL have port req_size, in, 2: 00 byte, 01 half, 10 word, 11 reserved.
REQ-010 SHALL have port req_signed, in, 1: sign-extend sub-word loads.
REQ-011 SHALL have port req_addr, in, 32: byte address.
REQ-012 SHALL have port req_wdata, in, WORD_SIZE: store data, right-aligned.
REQ-013 SHALL have port resp_valid, out, 1: one-cycle completion pulse; no backpressure.
REQ-014 SHALL have port resp_rdata, out, WORD_SIZE: extended load data.
REQ-015 SHALL have port resp_err, out, 1: misaligned, reserved size, or timeout; valid with resp_valid.
REQ-016 SHALL have port mem_enable, out, 1: memory ENABLE.
REQ-017 SHALL have port mem_rnw, out, 1: memory READNOTWRITE.
REQ-018 SHALL have port mem_address, out, ADDRESS_SIZE: word address = req_addr[ADDRESS_SIZE+1:2].
REQ-019 SHALL have port mem_data, inout, WORD_SIZE: shared memory data bus.
REQ-020 SHALL have port mem_data_ready, in, 1: memory DATA_READY.

Function
REQ-021 SHALL implement FSM states IDLE, RD, WR, RMW_RD, GAP, RMW_WR, RESP.
REQ-022 SHALL assert req_ready only in IDLE; request fields latched on acceptance.
REQ-023 SHALL, on acceptance, go to RESP with error set, issuing no memory access, when size=11, half with addr[0]=1, or word with addr[1:0]!=00.
REQ-024 SHALL otherwise go: load -> RD; word store -> WR; byte/half store -> RMW_RD.
REQ-025 SHALL drive mem_enable=1 only in RD, WR, RMW_RD, RMW_WR; mem_rnw=0 only in WR, RMW_WR, else 1.
REQ-026 SHALL drive mem_data = write word only when mem_enable && !mem_rnw; hi-Z otherwise.
REQ-027 SHALL ignore mem_data_ready in the first cycle of each access state (memory ready flag is sticky); completion = cycle count >= 1 && mem_data_ready.
REQ-028 SHALL, in RD/RMW_RD, capture mem_data on the completion edge.
REQ-029 SHALL use big-endian lanes: byte offset 0 = bits 31:24, half offset 0 = bits 31:16.
REQ-030 SHALL, in RMW_RD completion, merge req_wdata low byte/half into the captured word lane, then pass through GAP (one cycle, mem_enable=0) to RMW_WR.
REQ-031 SHALL, on RD/WR/RMW_WR completion, go to RESP; resp_rdata = selected lane zero- or sign-extended (loads), 0 for stores.
REQ-032 SHALL, on cycle count reaching TIMEOUT without completion in any access state, go to RESP with error set and resp_rdata=0.
REQ-033 SHALL, in RESP, assert resp_valid for exactly one cycle, then return to IDLE (mem_enable=0 that cycle).
REQ-034 SHALL yield load-word latency: accept edge cycle 0, mem_enable cycles 1-2, resp_valid cycle 3 with zero-wait memory.
REQ-035 SHALL reset the cycle counter on every access-state entry; counter width covers TIMEOUT.

Reset
REQ-036 SHALL, while rst=0, force state IDLE, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, mem_enable=0, mem_rnw=1, mem_address=0, mem_data hi-Z.
REQ-037 SHALL drop any in-flight transaction on reset assertion without issuing resp_valid; after release req_ready=1 on the first cycle.

Verification
REQ-038 SHALL check: word load addr 0x0000_0008, mem word 2 = 0xDEADBEEF -> mem_address=2, resp_valid cycle 3, resp_rdata=0xDEADBEEF, err=0.
REQ-039 SHALL check: signed byte load addr 0x9 from word 0x12F45678 -> resp_rdata=0xFFFFFFF4; unsigned -> 0x000000F4.
REQ-040 SHALL check: half store 0xABCD at addr 0x6 over word 0x11223344 -> RMW read, one idle gap, write 0x1122ABCD to mem_address=1.
REQ-041 SHALL check: word load addr 0x2 -> resp_valid cycle 1 with err=1, mem_enable never asserted.
REQ-042 SHALL check: mem_data_ready held 0 -> resp_err=1 after TIMEOUT=15 cycles, mem_enable drops in RESP.
REQ-043 SHALL check: rst pulsed low during RMW_WR -> mem_enable=0 and mem_data hi-Z immediately, no resp_valid, req_ready=1 after release.
